rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the cycles a queued MDU write may wait before stall_req asserts (legal range 1..15).
REQ-002 SHALL have clk  in  1  clock; reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have p_we  in  1  pipeline W-stage write enable.
REQ-004 SHALL have p_wa  in  5 / p_wd  in  32 / p_pc  in  32: pipeline destination, data and PC.
REQ-005 SHALL have m_valid  in  1 / m_ready  out  1: MDU result handshake.
REQ-006 SHALL have m_wa  in  5 / m_wd  in  32 / m_pc  in  32: MDU destination, data and PC.
REQ-007 SHALL have rf_we  out  1 / rf_wa  out  5 / rf_wd  out  32 / rf_wpc  out  32: the single RF write port.
REQ-008 SHALL have m_pend  out  32: mask of registers with queued MDU writes.
REQ-009 SHALL have stall_req  out  1: request that the pipeline freeze W.
REQ-010 SHALL have q_count  out  2: FIFO occupancy, 0..2.

Function
REQ-011 SHALL hold a 2-entry in-order FIFO of {wa, wd, pc} for MDU results.
REQ-012 SHALL drive m_ready = !reset && (q_count < 2), computed from the registered count and independent of m_valid.
REQ-013 SHALL count an MDU transfer as accepted when m_valid && m_ready.
REQ-014 SHALL treat a pipeline request (p_req) as present iff p_we && p_wa != 0; a p_we with p_wa = 0 SHALL be ignored.
REQ-015 SHALL drive the write port combinationally (0-cycle latency), with priority order: p_req, then FIFO head, then MDU bypass.
REQ-016 If p_req is present, rf_* SHALL carry p_wa/p_wd/p_pc with rf_we = 1; the pipeline is never backpressured.
REQ-017 Else if q_count > 0, rf_* SHALL carry the head entry with rf_we = 1, and the head SHALL dequeue at the clock edge.
REQ-018 Else if an MDU transfer is accepted with m_wa != 0, rf_* SHALL carry m_wa/m_wd/m_pc directly (bypass) and nothing is enqueued.
REQ-019 Otherwise rf_we SHALL be 0, and rf_wa/rf_wd/rf_wpc SHALL be 0.
REQ-020 Any accepted MDU transfer not bypassed and with m_wa != 0 SHALL enqueue at the tail.
REQ-021 Accepted transfers with m_wa = 0 SHALL be consumed and dropped.
REQ-022 Simultaneous dequeue and enqueue in one cycle SHALL leave q_count unchanged and preserve order.
REQ-023 When q_count = 2, m_ready SHALL be 0 even if a dequeue occurs that cycle.
REQ-024 m_pend SHALL be the OR of one-hot(wa) over valid FIFO entries, from registered state only; bit 0 is always 0.
REQ-025 The block SHALL NOT reorder writes. Decode SHALL stall any instruction whose destination is set in m_pend (this is the contract).
REQ-026 A pipeline write to a register set in m_pend is a protocol violation and SHALL be flagged by bench assertion.

Reset
REQ-027 On a reset edge, q_count SHALL become 0, FIFO contents SHALL be discarded, and the wait counter SHALL become 0.
REQ-028 While reset = 1, the block SHALL drive rf_we = 0, m_ready = 0, stall_req = 0 and m_pend = 0, regardless of p_we or m_valid.
REQ-029 Reset asserted mid-operation SHALL drop queued writes without writing them; the first cycle after reset behaves as empty.

Configuration
REQ-030 Macro STARVE_GUARD_EN SHALL control the starvation guard.
- Defined: a 4-bit wait counter increments each cycle q_count > 0 and no dequeue occurs, saturates at 15, and clears on dequeue or empty.
- Defined: stall_req = (wait_cnt >= STARVE_LIMIT), registered-state only.
- Defined: stall_req stays high until a dequeue occurs.
REQ-031 Without STARVE_GUARD_EN, the wait counter SHALL be absent and stall_req SHALL be tied 0; all other behaviour is identical.

Verification
REQ-032 Empty FIFO, p_we = 0, m_valid = 1, m_wa = 5, m_wd = 0xA5 -> same cycle: rf_we = 1, rf_wa = 5, rf_wd = 0xA5; q_count stays 0.
REQ-033 p_we = 1, p_wa = 3 and m_valid = 1, m_wa = 7 in the same cycle -> rf_wa = 3, q_count = 1, m_pend = 0x80; next cycle with p_we = 0 -> rf_wa = 7, q_count = 0.
REQ-034 Fill the FIFO with regs 8 and 9 under continuous p_we -> q_count = 2, m_ready = 0, m_pend = 0x300; m_valid is held and no transfer occurs.
REQ-035 STARVE_GUARD_EN defined, STARVE_LIMIT = 4, one entry queued, p_we held high -> stall_req rises after 4 waiting cycles; on p_we = 0 the head writes and stall_req falls the next cycle.
REQ-036 Reset pulsed with q_count = 2 -> no RF write of the queued entries; after reset q_count = 0, m_pend = 0, m_ready = 1.
REQ-037 m_valid = 1 with m_wa = 0 on an empty FIFO -> transfer accepted, rf_we = 0, q_count stays 0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges pipeline W-stage writes and MDU results onto the
// single register-file write port. MDU results that lose arbitration wait in
// a 2-entry in-order FIFO; m_pend exposes their destinations to decode.
// Optional feature macro: STARVE_GUARD_EN (wait counter + stall_req).
module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_we,
  input  logic [4:0]  p_wa,
  input  logic [31:0] p_wd,
  input  logic [31:0] p_pc,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [4:0]  m_wa,
  input  logic [31:0] m_wd,
  input  logic [31:0] m_pc,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [31:0] rf_wpc,
  output logic [31:0] m_pend,
  output logic        stall_req,
  output logic [1:0]  q_count
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("rf_wb_arbiter: STARVE_LIMIT must be in 1..15");
  end

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pc;
  } entry_t;

  entry_t     e0_q, e0_d;   // head
  entry_t     e1_q, e1_d;   // second entry, valid only when count is 2
  logic [1:0] count_q, count_d;

  logic   p_req, m_acc, deq, bypass, enq;
  logic [1:0] cnt_left;
  entry_t m_ent;

  assign m_ent   = '{wa: m_wa, wd: m_wd, pc: m_pc};
  assign q_count = count_q;
  assign m_ready = !reset && (count_q < 2'd2);

  // Arbitration: pipeline first, then FIFO head, then MDU bypass.
  always_comb begin
    p_req  = p_we && (p_wa != 5'd0);
    m_acc  = m_valid && m_ready;
    deq    = 1'b0;
    bypass = 1'b0;
    rf_we  = 1'b0;
    rf_wa  = 5'd0;
    rf_wd  = 32'd0;
    rf_wpc = 32'd0;
    if (!reset) begin
      if (p_req) begin
        rf_we  = 1'b1;
        rf_wa  = p_wa;
        rf_wd  = p_wd;
        rf_wpc = p_pc;
      end else if (count_q != 2'd0) begin
        deq    = 1'b1;
        rf_we  = 1'b1;
        rf_wa  = e0_q.wa;
        rf_wd  = e0_q.wd;
        rf_wpc = e0_q.pc;
      end else if (m_acc && (m_wa != 5'd0)) begin
        bypass = 1'b1;
        rf_we  = 1'b1;
        rf_wa  = m_wa;
        rf_wd  = m_wd;
        rf_wpc = m_pc;
      end
    end
    // m_wa == 0 transfers are accepted and silently dropped.
    enq = m_acc && (m_wa != 5'd0) && !bypass;
  end

  // FIFO next state: shift out the head first, then append at the tail.
  always_comb begin
    cnt_left = count_q - {1'b0, deq};
    e0_d     = deq ? e1_q : e0_q;
    e1_d     = e1_q;
    count_d  = cnt_left;
    if (enq) begin
      if (cnt_left == 2'd0) e0_d = m_ent;
      else                  e1_d = m_ent;
      count_d = cnt_left + 2'd1;
    end
    if (reset) begin
      count_d = 2'd0;
      e0_d    = '0;
      e1_d    = '0;
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    count_q <= count_d;
    e0_q    <= e0_d;
    e1_q    <= e1_d;
  end

  // Pending-destination mask from registered FIFO state.
  always_comb begin
    m_pend = 32'd0;
    if (!reset) begin
      if (count_q != 2'd0) m_pend[e0_q.wa] = 1'b1;
      if (count_q == 2'd2) m_pend[e1_q.wa] = 1'b1;
    end
    m_pend[0] = 1'b0;
  end

`ifdef STARVE_GUARD_EN
  logic [3:0] wait_q, wait_d;

  // Wait counter: cycles the head has been blocked, saturating at 15.
  always_comb begin
    wait_d = wait_q;
    if (reset || (count_q == 2'd0) || deq) wait_d = 4'd0;
    else if (wait_q != 4'hF)               wait_d = wait_q + 4'd1;
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    wait_q <= wait_d;
  end

  assign stall_req = !reset && (wait_q >= 4'(STARVE_LIMIT));
`else
  assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: directed vectors, RF writes checked by a
// scoreboard monitor, registered status checked inline.
module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        p_we;
  logic [4:0]  p_wa;
  logic [31:0] p_wd, p_pc;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  m_wa;
  logic [31:0] m_wd, m_pc;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd, rf_wpc;
  logic [31:0] m_pend;
  logic        stall_req;
  logic [1:0]  q_count;

  int checks = 0;
  int errors = 0;
  logic [68:0] exp_q[$];
  bit          done = 1'b0;

  rf_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .p_we(p_we), .p_wa(p_wa), .p_wd(p_wd), .p_pc(p_pc),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_wa(m_wa), .m_wd(m_wd), .m_pc(m_pc),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_wpc(rf_wpc),
    .m_pend(m_pend), .stall_req(stall_req), .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every RF write must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rf_write: unexpected write wa=%0d wd=0x%0h pc=0x%0h at %0t",
                 rf_wa, rf_wd, rf_wpc, $time);
      end else begin
        logic [68:0] e;
        e = exp_q.pop_front();
        if ({rf_wa, rf_wd, rf_wpc} !== e) begin
          errors++;
          $display("FAIL rf_write: got wa=%0d wd=0x%0h pc=0x%0h expected wa=%0d wd=0x%0h pc=0x%0h at %0t",
                   rf_wa, rf_wd, rf_wpc, e[68:64], e[63:32], e[31:0], $time);
        end
      end
    end
    if (!reset && p_we && p_wa != 5'd0 && m_pend[p_wa]) begin
      errors++;
      $display("FAIL protocol: pipeline write to pending reg %0d at %0t", p_wa, $time);
    end
  end

  // Watchdog.
  initial begin
    repeat (2000) @(posedge clk);
    if (!done) begin
      $display("FAIL watchdog: stimulus did not complete");
      $fatal(1, "timeout");
    end
  end

  task automatic drv(input logic pwe, input logic [4:0] pwa, input logic [31:0] pwd, input logic [31:0] ppc,
                     input logic mv, input logic [4:0] mwa, input logic [31:0] mwd, input logic [31:0] mpc);
    p_we = pwe; p_wa = pwa; p_wd = pwd; p_pc = ppc;
    m_valid = mv; m_wa = mwa; m_wd = mwd; m_pc = mpc;
  endtask

  task automatic expw(input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc);
    exp_q.push_back({wa, wd, pc});
  endtask

  // Advance: let the monitor sample this cycle, then move past the next edge.
  task automatic mid();
    @(negedge clk);
  endtask
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    drv(1, 5'd4, 32'h44, 32'h10, 1, 5'd6, 32'h66, 32'h14);
    nxt(); mid();
    chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset_m_ready", {31'd0, m_ready}, 32'd0);
    chk("reset_stall", {31'd0, stall_req}, 32'd0);
    chk("reset_m_pend", m_pend, 32'd0);
    nxt(); mid();
    chk("reset_q_count", {30'd0, q_count}, 32'd0);
    nxt();
    reset = 1'b0;

    // Bypass on empty FIFO.
    drv(0, 0, 0, 0, 1, 5'd5, 32'hA5, 32'h100);
    expw(5'd5, 32'hA5, 32'h100);
    mid();
    chk("byp_m_ready", {31'd0, m_ready}, 32'd1);
    chk("byp_q_count", {30'd0, q_count}, 32'd0);
    nxt();

    // m_wa = 0 transfer dropped.
    drv(0, 0, 0, 0, 1, 5'd0, 32'hDEAD, 32'h104);
    mid();
    chk("drop_q_count_before", {30'd0, q_count}, 32'd0);
    chk("drop_m_ready", {31'd0, m_ready}, 32'd1);
    nxt();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("drop_q_count_after", {30'd0, q_count}, 32'd0);
    nxt();

    // Pipeline wins, MDU queued then drained.
    drv(1, 5'd3, 32'h33, 32'h200, 1, 5'd7, 32'h77, 32'h204);
    expw(5'd3, 32'h33, 32'h200);
    nxt();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    expw(5'd7, 32'h77, 32'h204);
    mid();
    chk("q1_q_count", {30'd0, q_count}, 32'd1);
    chk("q1_m_pend", m_pend, 32'h80);
    nxt(); mid();
    chk("q1_drained", {30'd0, q_count}, 32'd0);
    chk("q1_pend_clear", m_pend, 32'd0);
    nxt();

    // Fill to 2 under continuous pipeline writes.
    drv(1, 5'd1, 32'h11, 32'h300, 1, 5'd8, 32'h88, 32'h800);
    expw(5'd1, 32'h11, 32'h300);
    nxt();
    drv(1, 5'd2, 32'h22, 32'h304, 1, 5'd9, 32'h99, 32'h900);
    expw(5'd2, 32'h22, 32'h304);
    mid();
    chk("fill_q1", {30'd0, q_count}, 32'd1);
    chk("fill_pend1", m_pend, 32'h100);
    nxt();
    for (int k = 0; k < 2; k++) begin
      drv(1, 5'd10, 32'hA0 + k, 32'h308 + 4 * k, 1, 5'd11, 32'hBB, 32'hB00);
      expw(5'd10, 32'hA0 + k, 32'h308 + 4 * k);
      mid();
      chk("full_q_count", {30'd0, q_count}, 32'd2);
      chk("full_m_ready", {31'd0, m_ready}, 32'd0);
      chk("full_m_pend", m_pend, 32'h300);
      nxt();
    end
    drv(0, 0, 0, 0, 1, 5'd11, 32'hBB, 32'hB00);
    expw(5'd8, 32'h88, 32'h800);
    mid();
    chk("full_deq_m_ready", {31'd0, m_ready}, 32'd0);
    nxt();
    expw(5'd9, 32'h99, 32'h900);
    mid();
    chk("deq_enq_q_count", {30'd0, q_count}, 32'd1);
    chk("deq_enq_m_ready", {31'd0, m_ready}, 32'd1);
    chk("deq_enq_pend", m_pend, 32'h200);
    nxt();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    expw(5'd11, 32'hBB, 32'hB00);
    mid();
    chk("order_q_count", {30'd0, q_count}, 32'd1);
    chk("order_pend", m_pend, 32'h800);
    nxt(); mid();
    chk("order_empty", {30'd0, q_count}, 32'd0);
    nxt();

    // Starvation guard: one entry waiting behind a busy pipeline.
    drv(1, 5'd1, 32'h1000, 32'h400, 1, 5'd12, 32'hCC, 32'hC00);
    expw(5'd1, 32'h1000, 32'h400);
    nxt();
    for (int k = 0; k < 6; k++) begin
      drv(1, 5'd2, 32'h2000 + k, 32'h404 + 4 * k, 0, 0, 0, 0);
      expw(5'd2, 32'h2000 + k, 32'h404 + 4 * k);
      mid();
`ifdef STARVE_GUARD_EN
      chk("starve_stall", {31'd0, stall_req}, {31'd0, k >= 4});
`else
      chk("starve_stall_off", {31'd0, stall_req}, 32'd0);
`endif
      nxt();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    expw(5'd12, 32'hCC, 32'hC00);
    mid();
`ifdef STARVE_GUARD_EN
    chk("starve_stall_held", {31'd0, stall_req}, 32'd1);
`endif
    nxt(); mid();
    chk("starve_stall_fall", {31'd0, stall_req}, 32'd0);
    chk("starve_empty", {30'd0, q_count}, 32'd0);
    nxt();

    // Reset with a full FIFO discards the queued writes.
    drv(1, 5'd1, 32'h5000, 32'h500, 1, 5'd13, 32'hDD, 32'hD00);
    expw(5'd1, 32'h5000, 32'h500);
    nxt();
    drv(1, 5'd2, 32'h5001, 32'h504, 1, 5'd14, 32'hEE, 32'hE00);
    expw(5'd2, 32'h5001, 32'h504);
    nxt();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    mid();
    chk("rst_mid_m_ready", {31'd0, m_ready}, 32'd0);
    chk("rst_mid_m_pend", m_pend, 32'd0);
    nxt();
    reset = 1'b0;
    mid();
    chk("rst_after_q", {30'd0, q_count}, 32'd0);
    chk("rst_after_pend", m_pend, 32'd0);
    chk("rst_after_m_ready", {31'd0, m_ready}, 32'd1);
    nxt();

    // p_we with p_wa = 0 is ignored; MDU bypasses.
    drv(1, 5'd0, 32'hFFFF, 32'h600, 1, 5'd15, 32'hF5, 32'hF00);
    expw(5'd15, 32'hF5, 32'hF00);
    mid();
    chk("pwa0_q_count", {30'd0, q_count}, 32'd0);
    nxt();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("pwa0_no_enq", {30'd0, q_count}, 32'd0);
    nxt(); mid();

    chk("all_writes_seen", exp_q.size(), 32'd0);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
